// File: rtl/multicycle_control.sv
// Sequencing controller for the multicycle RV32I datapath: Moore FSM stepping
// fetch/decode/execute/memory/writeback, datapath enables, ALU op decode and a retired-instruction counter.
module multicycle_control #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic [3:0]           alu_flags,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [3:0]           alu_control,
    output logic                 illegal_instr,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_JALR, S_JALR_LINK, S_BRANCH,
        S_LUI, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    state_t state, next_state;
    logic   branch_taken;
    logic   retire;

    // Only R-type may turn funct3=000 into sub; addi ignores instr[30].
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_r);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = alu_flags[0];
            3'b001:  branch_taken = ~alu_flags[0];
            3'b100:  branch_taken = alu_flags[1] ^ alu_flags[3];
            3'b101:  branch_taken = ~(alu_flags[1] ^ alu_flags[3]);
            3'b110:  branch_taken = alu_flags[2];
            3'b111:  branch_taken = ~alu_flags[2];
            default: branch_taken = 1'b0;
        endcase
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:     next_state = S_FETCH;
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_BRANCH:         next_state = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:    next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:     next_state = S_FETCH;
            S_MEMWRITE:  if (mem_ready) next_state = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:    next_state = S_ALUWB;
            S_ALUWB:     next_state = S_FETCH;
            S_JAL:       next_state = S_ALUWB;
            S_JALR:      next_state = S_JALR_LINK;
            S_JALR_LINK: next_state = S_ALUWB;
            default:     next_state = S_FETCH;
        endcase
    end

    // Illegal-instruction and reset paths back to FETCH do not count as retirement.
    assign retire = (next_state == S_FETCH) &&
                    (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB ||
                     state == S_BRANCH || state == S_LUI);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_RESET;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = IMM_I;
        alu_control   = ALU_ADD;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD:   adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7b5, 1'b1);
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_ALUWB:     reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = branch_taken;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            S_ILLEGAL:   illegal_instr = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its per-cycle
// expected control vectors, which are popped and compared cycle by cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_control #(.INSTRET_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_instr(illegal_instr), .instret(instret)
    );

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        rdy;
        logic [3:0]  flags;
        logic [18:0] exp;
        logic [31:0] exp_instret;
    } item_t;

    item_t       sb_q[$];
    string       tag_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_instret = '0;
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic        cur_f7;

    // Packing order: pc_write adr_src mem_write ir_write reg_write result_src a b imm alu illegal.
    function automatic logic [18:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    endfunction

    function automatic logic [18:0] e_fetch(input logic r);
        return ov(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 0);
    endfunction
    function automatic logic [18:0] e_decode(input logic is_jal);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, is_jal ? 3'b011 : 3'b010, 4'b0000, 0);
    endfunction
    function automatic logic [18:0] e_aluwb();
        return ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0);
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cur_op = op;
        cur_f3 = f3;
        cur_f7 = f7;
    endtask

    task automatic push(input string tag, input logic rdy, input logic [3:0] flags,
                        input logic [18:0] e);
        item_t it;
        it.op = cur_op;
        it.f3 = cur_f3;
        it.f7 = cur_f7;
        it.rdy = rdy;
        it.flags = flags;
        it.exp = e;
        it.exp_instret = model_instret;
        sb_q.push_back(it);
        tag_q.push_back(tag);
    endtask

    task automatic push_alu(input string tag, input logic is_r, input logic [2:0] f3,
                            input logic f7, input logic [3:0] alu);
        set_instr(is_r ? OP_R : OP_I, f3, f7);
        push({tag, ".fetch"}, 1, 4'h0, e_fetch(1));
        push({tag, ".decode"}, 1, 4'h0, e_decode(0));
        push({tag, ".exec"}, 1, 4'h0, is_r ? ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 0)
                                           : ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 0));
        push({tag, ".aluwb"}, 1, 4'h0, e_aluwb());
        model_instret++;
    endtask

    task automatic push_branch(input string tag, input logic [2:0] f3, input logic [3:0] flags,
                               input logic take);
        set_instr(OP_BRANCH, f3, 0);
        push({tag, ".fetch"}, 1, flags, e_fetch(1));
        push({tag, ".decode"}, 1, flags, e_decode(0));
        push({tag, ".branch"}, 1, flags, ov(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 0));
        model_instret++;
    endtask

    task automatic push_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3);
        set_instr(op, f3, 0);
        push({tag, ".fetch"}, 1, 4'h0, e_fetch(1));
        push({tag, ".decode"}, 1, 4'h0, e_decode(0));
        push({tag, ".illegal"}, 1, 4'h0, ov(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1));
    endtask

    // Pops each expected cycle, drives its inputs after the falling edge and compares mid-cycle.
    task automatic run_sb();
        item_t it;
        string tag;
        while (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            tag = tag_q.pop_front();
            @(negedge clk);
            opcode    = it.op;
            funct3    = it.f3;
            funct7b5  = it.f7;
            mem_ready = it.rdy;
            alu_flags = it.flags;
            #1;
            compared++;
            if (observed() !== it.exp) begin
                mismatched++;
                $display("FAIL %s ctrl: got %b want %b", tag, observed(), it.exp);
            end
            compared++;
            if (instret !== it.exp_instret) begin
                mismatched++;
                $display("FAIL %s instret: got %0d want %0d", tag, instret, it.exp_instret);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        alu_flags = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (observed() !== 19'd0) begin
            mismatched++;
            $display("FAIL reset.ctrl: got %b want all zero", observed());
        end
        compared++;
        if (instret !== 32'd0) begin
            mismatched++;
            $display("FAIL reset.instret: got %0d want 0", instret);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compared++;
        if (observed() !== 19'd0) begin
            mismatched++;
            $display("FAIL reset.release_cycle: got %b want all zero", observed());
        end
    endtask

    task automatic test_r_type();
        push_alu("add", 1, 3'b000, 0, 4'b0000);
        push_alu("sub", 1, 3'b000, 1, 4'b0001);
        push_alu("sra", 1, 3'b101, 1, 4'b1001);
        push_alu("sltu", 1, 3'b011, 0, 4'b0011);
        run_sb();
    endtask

    task automatic test_i_type();
        push_alu("srai", 0, 3'b101, 1, 4'b1001);
        push_alu("srli", 0, 3'b101, 0, 4'b1000);
        push_alu("addi_b30", 0, 3'b000, 1, 4'b0000);
        push_alu("ori", 0, 3'b110, 0, 4'b0110);
        run_sb();
    endtask

    task automatic test_branch();
        push_branch("bltu_c1", 3'b110, 4'b0100, 1);
        push_branch("bltu_c0", 3'b110, 4'b0000, 0);
        push_branch("blt_n1v1", 3'b100, 4'b1010, 0);
        push_branch("bge_n1v0", 3'b101, 4'b0010, 0);
        push_branch("beq_z1", 3'b000, 4'b0001, 1);
        push_branch("bne_z1", 3'b001, 4'b0001, 0);
        push_branch("bgeu_c0", 3'b111, 4'b0000, 1);
        run_sb();
    endtask

    task automatic test_load_stall();
        set_instr(OP_LOAD, 3'b010, 0);
        push("lw.fetch", 1, 4'h0, e_fetch(1));
        push("lw.decode", 1, 4'h0, e_decode(0));
        push("lw.memadr", 1, 4'h0, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 0));
        for (int i = 0; i < 4; i++)
            push("lw.memread", (i == 3), 4'h0, ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
        push("lw.memwb", 1, 4'h0, ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
        model_instret++;
        run_sb();
    endtask

    task automatic test_store_stall();
        set_instr(OP_STORE, 3'b010, 0);
        push("sw.fetch_wait", 0, 4'h0, e_fetch(0));
        push("sw.fetch", 1, 4'h0, e_fetch(1));
        push("sw.decode", 1, 4'h0, e_decode(0));
        push("sw.memadr", 1, 4'h0, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 0));
        push("sw.memwrite_wait", 0, 4'h0, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
        push("sw.memwrite", 1, 4'h0, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
        model_instret++;
        run_sb();
    endtask

    task automatic test_jumps_lui();
        set_instr(OP_JAL, 3'b000, 0);
        push("jal.fetch", 1, 4'h0, e_fetch(1));
        push("jal.decode", 1, 4'h0, e_decode(1));
        push("jal.jal", 1, 4'h0, ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 0));
        push("jal.aluwb", 1, 4'h0, e_aluwb());
        model_instret++;
        set_instr(OP_JALR, 3'b000, 0);
        push("jalr.fetch", 1, 4'h0, e_fetch(1));
        push("jalr.decode", 1, 4'h0, e_decode(0));
        push("jalr.jalr", 1, 4'h0, ov(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'b0000, 0));
        push("jalr.link", 1, 4'h0, ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 0));
        push("jalr.aluwb", 1, 4'h0, e_aluwb());
        model_instret++;
        set_instr(OP_LUI, 3'b000, 0);
        push("lui.fetch", 1, 4'h0, e_fetch(1));
        push("lui.decode", 1, 4'h0, e_decode(0));
        push("lui.lui", 1, 4'h0, ov(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b100, 4'b0000, 0));
        model_instret++;
        run_sb();
    endtask

    task automatic test_illegal();
        push_illegal("op0", 7'b0000000, 3'b000);
        push_illegal("br_f3_010", OP_BRANCH, 3'b010);
        push_illegal("br_f3_011", OP_BRANCH, 3'b011);
        push_alu("after_illegal", 1, 3'b100, 0, 4'b0100);
        run_sb();
    endtask

    task automatic test_reset_mid();
        set_instr(OP_STORE, 3'b010, 0);
        push("abort.fetch", 1, 4'h0, e_fetch(1));
        push("abort.decode", 1, 4'h0, e_decode(0));
        push("abort.memadr", 1, 4'h0, ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 0));
        push("abort.memwrite", 0, 4'h0, ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 0));
        run_sb();
        reset_n = 1'b0;
        #1;
        model_instret = '0;
        compared++;
        if (mem_write !== 1'b0 || observed() !== 19'd0) begin
            mismatched++;
            $display("FAIL abort.ctrl: got %b want all zero", observed());
        end
        compared++;
        if (instret !== 32'd0) begin
            mismatched++;
            $display("FAIL abort.instret: got %0d want 0", instret);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compared++;
        if (observed() !== 19'd0) begin
            mismatched++;
            $display("FAIL abort.release_cycle: got %b want all zero", observed());
        end
        push_alu("post_abort_and", 1, 3'b111, 0, 4'b0101);
        push_alu("post_abort_slt", 0, 3'b010, 0, 4'b0010);
        run_sb();
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_branch();
        test_load_stall();
        test_store_stall();
        test_jumps_lui();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle RV32I datapath. It decodes the latched instruction fields, steps a Moore state machine through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It produces the 4-bit `alu_control` consumed by the ALU and reads back the ALU's `alu_flags` to resolve branches. It also handles the instruction/data memory ready handshake and counts retired instructions.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `alu_flags`  in  4  from the ALU: [0] zero, [1] neg, [2] carry (unsigned borrow on sub), [3] overflow.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = result bus.
- `mem_write`  out  1  data store strobe.
- `ir_write`  out  1  instruction register and old-PC load enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result bus select: 00 = ALUOut reg, 01 = mem data reg, 10 = ALU result, 11 = immediate.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 reg.
- `alu_src_b`  out  2  ALU B select: 00 = rs2 reg, 01 = immediate, 10 = constant 4.
- `imm_src`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `alu_control`  out  4  0000 add, 0001 sub, 0010 slt, 0011 sltu, 0100 xor, 0101 and, 0110 or, 0111 sll, 1000 srl, 1001 sra.
- `illegal_instr`  out  1  one-cycle pulse on an unsupported opcode or branch funct3.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- Outputs not listed for a state are 0. Default `alu_control` is add.
- **RESET**: entered asynchronously while `reset_n` = 0. All outputs are 0 and `instret` = 0. Goes to FETCH on the first clock edge after reset release.
- **FETCH**: adr_src=0, a=00, b=10, result_src=10. `ir_write` and `pc_write` equal `mem_ready`. Holds in FETCH while `mem_ready` = 0; goes to DECODE when `mem_ready` = 1.
- **DECODE**: a=01, b=01, add, which computes the target old_pc+imm into ALUOut. imm_src = J when opcode is 1101111, otherwise B. Next state by opcode:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 1100011 → BRANCH, or ILLEGAL when funct3 is 010 or 011.
  - 0110111 → LUI.
  - any other opcode → ILLEGAL.
- **MEMADR**: a=10, b=01, add. imm_src = I for a load, S for a store. Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**: adr_src=1, result_src=00. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB**: result_src=01, reg_write=1 → FETCH.
- **MEMWRITE**: adr_src=1, result_src=00, mem_write=1. Holds until `mem_ready`, then goes to FETCH.
- **EXEC_R / EXEC_I**: a=10. b=00 for EXEC_R; b=01 with imm_src=I for EXEC_I. `alu_control` is decoded from funct3:
  - 000: add, or sub when R-type and funct7b5=1.
  - 001: sll.
  - 010: slt.
  - 011: sltu.
  - 100: xor.
  - 101: sra when funct7b5=1, else srl (both R-type and I-type).
  - 110: or.
  - 111: and.
  - Next state is ALUWB.
- **ALUWB**: result_src=00, reg_write=1 → FETCH.
- **JAL**: a=01, b=10, add, result_src=00, pc_write=1 → ALUWB.
- **JALR**: a=10, b=01, imm_src=I, add, result_src=10, pc_write=1 → JALR_LINK.
- **JALR_LINK**: a=01, b=10, add → ALUWB.
- **BRANCH**: a=10, b=00, sub, result_src=00. `pc_write` is decoded combinationally from funct3 and the flags:
  - 000 (beq): zero.
  - 001 (bne): ~zero.
  - 100 (blt): neg^ovf.
  - 101 (bge): ~(neg^ovf).
  - 110 (bltu): carry.
  - 111 (bgeu): ~carry.
  - Next state is FETCH.
- **LUI**: imm_src=U, result_src=11, reg_write=1 → FETCH.
- **ILLEGAL**: illegal_instr=1 → FETCH.
- **instret**: increments by 1 (wrapping modulo 2^INSTRET_W) on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI. ILLEGAL and RESET transitions into FETCH do not increment it.

## Timing
- The state register updates on the `clk` rising edge. Reset clears it asynchronously.
- All outputs are combinational from the state, with these exceptions:
  - BRANCH `pc_write` also depends on `alu_flags` and funct3.
  - FETCH `ir_write`/`pc_write` also depend on `mem_ready`.
  - EXEC `alu_control` also depends on funct3 and funct7b5.
- Cycle counts with zero-wait memory:
  - load: 5.
  - store: 4.
  - R-type / I-type: 4.
  - branch: 3.
  - jal: 4.
  - jalr: 5.
  - lui: 3.
  - illegal: 3.
- Each cycle with `mem_ready` = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. `mem_write` stays asserted throughout a MEMWRITE stall.
- Reset asserted mid-instruction aborts it immediately: all outputs go to 0 in the same cycle, and `instret` is not incremented.

## Test plan
- Reset release, then `add x3,x1,x2` with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALUWB. EXEC_R alu_control=0000, ALUWB reg_write=1, instret 0→1 on the 5th edge after release.
- `sub` (funct7b5=1) and `srai` (I-type, funct3=101, funct7b5=1) → alu_control 0001 and 1001 respectively. `srli` → 1000.
- `bltu` in BRANCH: alu_flags carry=1 → pc_write=1, carry=0 → pc_write=0. `blt` with neg=1, ovf=1 → pc_write=0. `beq` with zero=1 → pc_write=1.
- Load with mem_ready held low for 3 cycles in MEMREAD → MEMREAD lasts 4 cycles, load totals 8 cycles, reg_write asserted exactly once with result_src=01.
- Opcode 0000000 → DECODE then ILLEGAL: illegal_instr high for exactly 1 cycle, next state FETCH, instret unchanged.
- `reset_n` dropped during MEMWRITE → mem_write=0 in the same cycle, instret=0. After release: 1 cycle in RESET, then FETCH.
